// File: rtl/pipe_flow_ctrl.sv
// Pipeline flow controller: per-register WORK/STOP/REFRESH codes from hazards,
// data-memory wait handling with timeout, and a saturating stall statistic.
module pipe_flow_ctrl #(
  parameter int FLOW_WIDTH      = 2,
  parameter int MEM_TIMEOUT     = 16,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       jump_i,
  input  logic                       load_use_i,
  input  logic                       pr_acess_mem_flag_i,
  input  logic                       mem_ready_i,
  output logic [FLOW_WIDTH-1:0]      flow_pc_o,
  output logic [FLOW_WIDTH-1:0]      flow_if_o,
  output logic [FLOW_WIDTH-1:0]      flow_id_o,
  output logic [FLOW_WIDTH-1:0]      flow_ex_o,
  output logic [FLOW_WIDTH-1:0]      flow_as_o,
  output logic                       mem_req_o,
  output logic                       timeout_o,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt_o
);

  // state    | meaning
  // RUN      | normal issue, hazard rules active
  // MEM_WAIT | data access outstanding, pipeline frozen until ready
  // TOUT     | access abandoned, flush whole pipeline for one cycle
  typedef enum logic [1:0] {RUN, MEM_WAIT, TOUT} state_e;

  localparam logic [FLOW_WIDTH-1:0] WORK    = FLOW_WIDTH'(2'b00);
  localparam logic [FLOW_WIDTH-1:0] STOP    = FLOW_WIDTH'(2'b01);
  localparam logic [FLOW_WIDTH-1:0] REFRESH = FLOW_WIDTH'(2'b10);

  localparam logic [7:0]                 WAIT_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [STALL_CNT_WIDTH-1:0] STALL_ONE = STALL_CNT_WIDTH'(1);

  state_e                     state_q, state_d;
  logic [7:0]                 wait_q, wait_d;
  logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;

  logic [FLOW_WIDTH-1:0] pc_f, if_f, id_f, ex_f, as_f;
  logic                  tout_f;
  logic                  run_rules;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    pc_f      = WORK;
    if_f      = WORK;
    id_f      = WORK;
    ex_f      = WORK;
    as_f      = WORK;
    tout_f    = 1'b0;
    run_rules = 1'b0;

    case (state_q)
      RUN: run_rules = 1'b1;
      MEM_WAIT: begin
        if (mem_ready_i) begin
          run_rules = 1'b1;
        end else begin
          pc_f = STOP;
          if_f = STOP;
          id_f = STOP;
          ex_f = STOP;
          as_f = STOP;
          if (wait_q == WAIT_LAST) state_d = TOUT;
          else                     wait_d  = wait_q + 8'd1;
        end
      end
      TOUT: begin
        pc_f    = REFRESH;
        if_f    = REFRESH;
        id_f    = REFRESH;
        ex_f    = REFRESH;
        as_f    = REFRESH;
        tout_f  = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    // Hazard flows and the memory-flag transition are independent of each other.
    if (run_rules) begin
      if (jump_i) begin
        if_f = REFRESH;
        id_f = REFRESH;
      end else if (load_use_i) begin
        pc_f = STOP;
        if_f = STOP;
        id_f = REFRESH;
      end
      if (pr_acess_mem_flag_i) begin
        state_d = MEM_WAIT;
        wait_d  = 8'd0;
      end else begin
        state_d = RUN;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (flow_pc_o == STOP && stall_q != '1) stall_d = stall_q + STALL_ONE;
  end

  assign flow_pc_o   = rst_n ? pc_f : REFRESH;
  assign flow_if_o   = rst_n ? if_f : REFRESH;
  assign flow_id_o   = rst_n ? id_f : REFRESH;
  assign flow_ex_o   = rst_n ? ex_f : REFRESH;
  assign flow_as_o   = rst_n ? as_f : REFRESH;
  assign timeout_o   = rst_n & tout_f;
  assign mem_req_o   = (state_q == MEM_WAIT);
  assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Bench for pipe_flow_ctrl: table of per-cycle vectors through a scoreboard queue,
// plus hand sequences for reset during an access and stall-counter saturation.
module tb_pipe_flow_ctrl;

  localparam logic [1:0] W = 2'b00, S = 2'b01, R = 2'b10;

  typedef struct packed {
    logic [1:0]  pc, fi, id, ex, as;
    logic        req, tout;
    logic [15:0] stall;
  } out_t;

  typedef struct packed {
    logic j, lu, f, r;
    out_t exp;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic jump, lu, flag, rdy;
  logic [1:0] f_pc, f_if, f_id, f_ex, f_as;
  logic req, tout;
  logic [15:0] stall;

  logic lu2;
  logic [1:0] g_pc, g_if, g_id, g_ex, g_as;
  logic req2, tout2;
  logic [2:0] stall2;

  int n_cmp = 0, n_bad = 0;
  out_t exp_q[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  pipe_flow_ctrl #(.FLOW_WIDTH(2), .MEM_TIMEOUT(4), .STALL_CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .jump_i(jump), .load_use_i(lu),
    .pr_acess_mem_flag_i(flag), .mem_ready_i(rdy),
    .flow_pc_o(f_pc), .flow_if_o(f_if), .flow_id_o(f_id), .flow_ex_o(f_ex), .flow_as_o(f_as),
    .mem_req_o(req), .timeout_o(tout), .stall_cnt_o(stall));

  pipe_flow_ctrl #(.FLOW_WIDTH(2), .MEM_TIMEOUT(16), .STALL_CNT_WIDTH(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .jump_i(1'b0), .load_use_i(lu2),
    .pr_acess_mem_flag_i(1'b0), .mem_ready_i(1'b0),
    .flow_pc_o(g_pc), .flow_if_o(g_if), .flow_id_o(g_id), .flow_ex_o(g_ex), .flow_as_o(g_as),
    .mem_req_o(req2), .timeout_o(tout2), .stall_cnt_o(stall2));

  function automatic vec_t mk(logic j, logic l, logic f, logic r,
                              logic [1:0] pc, logic [1:0] fi, logic [1:0] id,
                              logic [1:0] ex, logic [1:0] as,
                              logic rq, logic to, int st);
    vec_t v;
    v.j = j; v.lu = l; v.f = f; v.r = r;
    v.exp = '{pc: pc, fi: fi, id: id, ex: ex, as: as, req: rq, tout: to, stall: 16'(st)};
    return v;
  endfunction

  task automatic check_pop(string name);
    out_t e, a;
    e = exp_q.pop_front();
    a = '{pc: f_pc, fi: f_if, id: f_id, ex: f_ex, as: f_as, req: req, tout: tout, stall: stall};
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got flows pc/if/id/ex/as=%b/%b/%b/%b/%b req=%b tout=%b stall=%0d, want %b/%b/%b/%b/%b req=%b tout=%b stall=%0d",
               name, a.pc, a.fi, a.id, a.ex, a.as, a.req, a.tout, a.stall,
               e.pc, e.fi, e.id, e.ex, e.as, e.req, e.tout, e.stall);
    end
  endtask

  // Called at posedge+1: drive, sample on the falling edge, advance to next posedge+1.
  task automatic step(vec_t v, string name);
    jump = v.j; lu = v.lu; flag = v.f; rdy = v.r;
    exp_q.push_back(v.exp);
    @(negedge clk);
    check_pop(name);
    @(posedge clk);
    #1;
  endtask

  initial begin
    jump = 0; lu = 0; flag = 0; rdy = 0; lu2 = 0;

    // idle / jump / priority / load-use
    vecs.push_back(mk(0,0,0,0, W,W,W,W,W, 0,0, 0));
    vecs.push_back(mk(1,0,0,0, W,R,R,W,W, 0,0, 0));
    vecs.push_back(mk(0,0,0,0, W,W,W,W,W, 0,0, 0));
    vecs.push_back(mk(1,1,0,0, W,R,R,W,W, 0,0, 0));
    vecs.push_back(mk(0,1,0,0, S,S,R,W,W, 0,0, 0));
    vecs.push_back(mk(0,0,0,0, W,W,W,W,W, 0,0, 1));
    // memory wait, ready on third cycle; hazards ignored while waiting
    vecs.push_back(mk(0,0,1,0, W,W,W,W,W, 0,0, 1));
    vecs.push_back(mk(1,0,0,0, S,S,S,S,S, 1,0, 1));
    vecs.push_back(mk(0,1,0,0, S,S,S,S,S, 1,0, 2));
    vecs.push_back(mk(0,0,0,1, W,W,W,W,W, 1,0, 3));
    vecs.push_back(mk(0,0,0,0, W,W,W,W,W, 0,0, 3));
    // back-to-back access, then the second one times out after exactly 4 waits
    vecs.push_back(mk(0,0,1,0, W,W,W,W,W, 0,0, 3));
    vecs.push_back(mk(0,0,0,0, S,S,S,S,S, 1,0, 3));
    vecs.push_back(mk(0,0,0,0, S,S,S,S,S, 1,0, 4));
    vecs.push_back(mk(0,0,1,1, W,W,W,W,W, 1,0, 5));
    vecs.push_back(mk(0,0,0,0, S,S,S,S,S, 1,0, 5));
    vecs.push_back(mk(0,0,0,0, S,S,S,S,S, 1,0, 6));
    vecs.push_back(mk(0,0,0,0, S,S,S,S,S, 1,0, 7));
    vecs.push_back(mk(0,0,0,0, S,S,S,S,S, 1,0, 8));
    vecs.push_back(mk(1,0,1,0, R,R,R,R,R, 0,1, 9));
    vecs.push_back(mk(0,0,0,0, W,W,W,W,W, 0,0, 9));
    // ready arrives on the timeout cycle: completion wins
    vecs.push_back(mk(0,0,1,0, W,W,W,W,W, 0,0, 9));
    vecs.push_back(mk(0,0,0,0, S,S,S,S,S, 1,0, 9));
    vecs.push_back(mk(0,0,0,0, S,S,S,S,S, 1,0, 10));
    vecs.push_back(mk(0,0,0,0, S,S,S,S,S, 1,0, 11));
    vecs.push_back(mk(0,0,0,1, W,W,W,W,W, 1,0, 12));
    vecs.push_back(mk(0,0,0,0, W,W,W,W,W, 0,0, 12));
    // stray ready in RUN ignored; jump together with memory flag
    vecs.push_back(mk(0,0,0,1, W,W,W,W,W, 0,0, 12));
    vecs.push_back(mk(1,0,1,0, W,R,R,W,W, 0,0, 12));
    vecs.push_back(mk(0,0,0,1, W,W,W,W,W, 1,0, 12));
    vecs.push_back(mk(0,0,0,0, W,W,W,W,W, 0,0, 12));

    #12;
    exp_q.push_back('{pc: R, fi: R, id: R, ex: R, as: R, req: 0, tout: 0, stall: 0});
    check_pop("reset_state");
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

    // reset asserted mid-access
    step(mk(0,0,1,0, W,W,W,W,W, 0,0, 12), "rst_enter_wait");
    step(mk(0,0,0,0, S,S,S,S,S, 1,0, 12), "rst_waiting");
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back('{pc: R, fi: R, id: R, ex: R, as: R, req: 0, tout: 0, stall: 0});
    check_pop("rst_async");
    @(posedge clk);
    @(negedge clk);
    exp_q.push_back('{pc: R, fi: R, id: R, ex: R, as: R, req: 0, tout: 0, stall: 0});
    check_pop("rst_held");
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(mk(1,0,0,0, W,R,R,W,W, 0,0, 0), "rst_resume_jump");
    step(mk(0,1,0,0, S,S,R,W,W, 0,0, 0), "rst_resume_lu");
    step(mk(0,0,0,0, W,W,W,W,W, 0,0, 1), "rst_resume_idle");

    // saturation of a 3-bit stall counter
    lu2 = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (stall2 !== 3'd7 || g_pc !== S) begin
      n_bad++;
      $display("FAIL stall_saturate: got stall=%0d pc=%b, want stall=7 pc=01", stall2, g_pc);
    end
    lu2 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (stall2 !== 3'd7) begin
      n_bad++;
      $display("FAIL stall_hold: got stall=%0d, want 7", stall2);
    end

    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at %0t, want completion", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_flow_ctrl.md
PIPE_FLOW_CTRL -- requirements
Module: pipe_flow_ctrl

Interface
REQ-001 SHALL have parameter FLOW_WIDTH, default 2: width of every flow code output.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16: maximum number of wait cycles for a memory access; legal range 2..255.
REQ-003 SHALL have parameter STALL_CNT_WIDTH, default 16: width of the stall statistics counter.
REQ-004 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port jump_i, input, 1 bit: branch or jump taken in the execute stage.
REQ-007 SHALL have port load_use_i, input, 1 bit: load-use hazard detected in the decode stage.
REQ-008 SHALL have port pr_acess_mem_flag_i, input, 1 bit: the instruction entering the access-memory register performs a load or store.
REQ-009 SHALL have port mem_ready_i, input, 1 bit: the data memory completes the pending access in this cycle.
REQ-010 SHALL have ports flow_pc_o, flow_if_o, flow_id_o, flow_ex_o and flow_as_o, output, FLOW_WIDTH bits each: flow codes for the PC register and the if_id, id_ex, ex_as and as_wb pipeline registers.
REQ-011 SHALL have port mem_req_o, output, 1 bit: a data memory access is outstanding.
REQ-012 SHALL have port timeout_o, output, 1 bit: one-cycle pulse when a memory access times out.
REQ-013 SHALL have port stall_cnt_o, output, STALL_CNT_WIDTH bits: saturating count of cycles in which flow_pc_o = STOP.

Function
REQ-014 SHALL use the flow encodings WORK = 2'b00, STOP = 2'b01 and REFRESH = 2'b10; 2'b11 SHALL never be driven.
REQ-015 SHALL implement the states RUN, MEM_WAIT and TOUT, with RUN as the reset state.
REQ-016 SHALL, in RUN, apply these rules in priority order; all flows not named are WORK:
  - jump_i = 1: if and id are REFRESH.
  - otherwise load_use_i = 1: pc and if are STOP, id is REFRESH.
REQ-017 SHALL, in RUN with pr_acess_mem_flag_i = 1, go to MEM_WAIT on the next cycle, independent of the REQ-016 outcome; jump and memory flag in the same cycle are both honoured.
REQ-018 SHALL, in MEM_WAIT with mem_ready_i = 0, drive all five flows as STOP and ignore jump_i and load_use_i.
REQ-019 SHALL drive mem_req_o = 1 exactly when the state is MEM_WAIT; mem_req_o is a combinational decode of the state.
REQ-020 SHALL, in MEM_WAIT with mem_ready_i = 1, apply the RUN rules (REQ-016/017) in that same cycle:
  - next state is MEM_WAIT if pr_acess_mem_flag_i = 1, else RUN.
  - back-to-back memory accesses incur no idle cycle.
REQ-021 SHALL keep a wait counter that clears on MEM_WAIT entry, re-entry included, and increments on each MEM_WAIT cycle with mem_ready_i = 0.
REQ-022 SHALL go to TOUT when the wait counter equals MEM_TIMEOUT-1 and mem_ready_i = 0; a memory access with no ready therefore spends exactly MEM_TIMEOUT cycles in MEM_WAIT.
REQ-023 SHALL, in TOUT (exactly 1 cycle), drive all five flows as REFRESH, timeout_o = 1 and mem_req_o = 0, then return to RUN.
REQ-024 SHALL treat mem_ready_i = 1 in the same cycle the timeout is reached as completion; ready wins and TOUT is not entered.
REQ-025 SHALL increment stall_cnt_o on each cycle with flow_pc_o = STOP and hold it at all-ones without wrapping.
REQ-026 SHALL ignore mem_ready_i outside MEM_WAIT.

Reset
REQ-027 SHALL, while rst_n = 0, drive all flows REFRESH, mem_req_o = 0 and timeout_o = 0.
REQ-028 SHALL, on reset assertion including mid-access, asynchronously set state = RUN, wait counter = 0 and stall_cnt_o = 0.
REQ-029 SHALL, on the first clock after rst_n is deasserted, evaluate the RUN rules.

Verification
REQ-030 SHALL pass the jump test: RUN, jump_i = 1 for 1 cycle -> flow_if/flow_id = 2'b10, flow_pc/ex/as = 2'b00; next cycle all 2'b00.
REQ-031 SHALL pass the hazard-priority test: jump_i = 1 and load_use_i = 1 together -> jump rule applied, flow_pc = 2'b00, stall_cnt_o unchanged.
REQ-032 SHALL pass the memory-wait test: pr_acess_mem_flag_i pulse, mem_ready_i = 1 three cycles later -> mem_req_o = 1 for 3 cycles, all flows 2'b01 for 2 cycles, stall_cnt_o = 2.
REQ-033 SHALL pass the back-to-back test: in MEM_WAIT, mem_ready_i = 1 with pr_acess_mem_flag_i = 1 -> flows 2'b00 that cycle, mem_req_o stays 1, wait counter restarts.
REQ-034 SHALL pass the timeout test: MEM_TIMEOUT = 4, mem_ready_i held 0 -> mem_req_o = 1 for 4 cycles, then 1 cycle with timeout_o = 1 and all flows 2'b10, then RUN.
REQ-035 SHALL pass the reset test: rst_n pulsed low during MEM_WAIT -> mem_req_o = 0 immediately, flows 2'b10 while low, stall_cnt_o = 0, RUN rules resume after release.
